gray_counter: RTL and testbench

Registered (N+1)-bit Gray-code counter with a configurable reset start value and a count enable. It generates the read and write pointers of the asynchronous FIFO. The extra MSB provides the wrap indication used for full/empty detection. An instance reset to 1 supplies the "next" write pointer, and an instance reset to 0 supplies the current read pointer. Only one output bit changes per increment, so the pointer can be safely synchronized into another clock domain.

---
 rtl/gray_cnt_pkg.sv | 28 ++
 rtl/gray_enc.sv | 14 +
 rtl/gray_counter.sv | 53 +++++
 tb/tb_gray_counter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/gray_cnt_pkg.sv
// Shared helpers for the async FIFO Gray-code pointers.
// Width helpers plus bin<->Gray conversion functions.
package gray_cnt_pkg;

  localparam int GC_MAX_W = 32;

  function automatic int cnt_w(input int n);
    return n + 1;
  endfunction

  function automatic logic [GC_MAX_W-1:0] bin2gray(
    input logic [GC_MAX_W-1:0] value
  );
    return value ^ (value >> 1);
  endfunction

  function automatic logic [GC_MAX_W-1:0] gray2bin(
    input logic [GC_MAX_W-1:0] value
  );
    logic [GC_MAX_W-1:0] b;
    b[GC_MAX_W-1] = value[GC_MAX_W-1];
    for (int i = GC_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ value[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_enc.sv
// Combinational binary to Gray-code encoder.
// Used to form the next registered Gray pointer.
module gray_enc
  import gray_cnt_pkg::*;
#(
  parameter int W = cnt_w(10)
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  assign gray = bin ^ {1'b0, bin[W-1:1]};

endmodule

// File: rtl/gray_counter.sv
// Registered (N+1)-bit Gray counter for async FIFO pointers.
// Define GRAY_CNT_BIN_OUT_EN to expose the binary count as bin_out.
module gray_counter
  import gray_cnt_pkg::*;
#(
  parameter int N         = 10,
  parameter int first_bit = 0
) (
  input  logic       clk,
  input  logic       rstp,
  input  logic       en,
  output logic [N:0] out
`ifdef GRAY_CNT_BIN_OUT_EN
  ,
  output logic [N:0] bin_out
`endif
);

  localparam int W = cnt_w(N);

  // Truncation gives first_bit mod 2^W.
  localparam logic [W-1:0] RST_BIN  = W'(first_bit);
  localparam logic [W-1:0] RST_GRAY =
    RST_BIN ^ {1'b0, RST_BIN[W-1:1]};

  logic [W-1:0] bin;
  logic [W-1:0] bin_nxt;
  logic [W-1:0] gray_nxt;

  assign bin_nxt = bin + W'(1);

  gray_enc #(
    .W (W)
  ) u_enc (
    .bin  (bin_nxt),
    .gray (gray_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rstp) begin
      bin <= RST_BIN;
      out <= RST_GRAY;
    end else if (en) begin
      bin <= bin_nxt;
      out <= gray_nxt;
    end
  end

`ifdef GRAY_CNT_BIN_OUT_EN
  assign bin_out = bin;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter.
// Reference: reflected Gray table and gray2bin decode of a cycle count.
module tb_gray_counter;
  import gray_cnt_pkg::*;

  logic clk = 1'b0;
  logic rstp;
  logic en_a;
  logic en_b;

  logic [2:0]  out0;
  logic [2:0]  out1;
  logic [2:0]  out3;
  logic [10:0] out2;
`ifdef GRAY_CNT_BIN_OUT_EN
  logic [10:0] bin2;
`endif

  int tests = 0;
  int fails = 0;
  int cnt_a = 0;
  int cnt_b = 0;

  logic [2:0] tbl [8];
  logic [2:0] prev0;
  logic [10:0] prev2;

  always #5 clk = ~clk;

  gray_counter #(.N(2), .first_bit(0)) u0 (
    .clk(clk), .rstp(rstp), .en(en_a), .out(out0)
`ifdef GRAY_CNT_BIN_OUT_EN
    , .bin_out()
`endif
  );

  gray_counter #(.N(2), .first_bit(1)) u1 (
    .clk(clk), .rstp(rstp), .en(en_a), .out(out1)
`ifdef GRAY_CNT_BIN_OUT_EN
    , .bin_out()
`endif
  );

  gray_counter #(.N(2), .first_bit(6)) u3 (
    .clk(clk), .rstp(rstp), .en(en_a), .out(out3)
`ifdef GRAY_CNT_BIN_OUT_EN
    , .bin_out()
`endif
  );

  gray_counter #(.N(10), .first_bit(0)) u2 (
    .clk(clk), .rstp(rstp), .en(en_b), .out(out2)
`ifdef GRAY_CNT_BIN_OUT_EN
    , .bin_out(bin2)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic ea, input logic eb);
    @(negedge clk);
    rstp = r;
    en_a = ea;
    en_b = eb;
    prev0 = out0;
    prev2 = out2;
    @(posedge clk);
    #1;
    if (!r) begin
      cnt_a = 0;
      cnt_b = 0;
    end else begin
      if (ea) cnt_a++;
      if (eb) cnt_b++;
    end
  endtask

  task automatic chk_small(input string tag);
    chk({tag, "_u0"}, 32'(out0), 32'(tbl[cnt_a % 8]));
    chk({tag, "_u1"}, 32'(out1), 32'(tbl[(cnt_a + 1) % 8]));
    chk({tag, "_u3"}, 32'(out3), 32'(tbl[(cnt_a + 6) % 8]));
  endtask

  task automatic chk_big(input string tag);
    chk({tag, "_dec"}, gray2bin(32'(out2)), 32'(cnt_b % 2048));
`ifdef GRAY_CNT_BIN_OUT_EN
    chk({tag, "_bin"}, 32'(bin2), 32'(cnt_b % 2048));
    chk({tag, "_cons"}, 32'(out2), 32'(bin2 ^ (bin2 >> 1)));
`endif
  endtask

  initial begin
    tbl[0] = 3'b000; tbl[1] = 3'b001;
    tbl[2] = 3'b011; tbl[3] = 3'b010;
    tbl[4] = 3'b110; tbl[5] = 3'b111;
    tbl[6] = 3'b101; tbl[7] = 3'b100;
    rstp = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;

    // Reset for two cycles, then idle with en low.
    step(0, 0, 0);
    step(0, 0, 0);
    chk_small("reset");
    chk_big("reset");
    step(1, 0, 0);
    chk_small("idle0");
    step(1, 0, 0);
    chk_small("idle1");
    chk_big("idle");

    // Full wrap of the N=2 counters.
    for (int k = 0; k < 8; k++) begin
      step(1, 1, 0);
      chk_small("seq");
      chk("seq_onebit", $countones(out0 ^ prev0), 1);
    end

    // Up to 110, pause three cycles, resume.
    for (int k = 0; k < 4; k++) step(1, 1, 0);
    chk("at110", 32'(out0), 32'h6);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0);
      chk("hold110", 32'(out0), 32'h6);
    end
    step(1, 1, 0);
    chk("resume111", 32'(out0), 32'h7);
    chk_small("resume");

    // Reset beats enable.
    step(0, 1, 1);
    chk_small("rst_prio");
    step(0, 1, 1);
    chk_small("rst_hold");
    chk_big("rst_prio");

    // Random enables on both counter groups.
    for (int k = 0; k < 2100; k++) begin
      step(1, 1'($urandom), 1'($urandom));
      chk_small("rnd");
      chk_big("rnd");
      if (out2 != prev2)
        chk("rnd_onebit", $countones(out2 ^ prev2), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
